// File: rtl/fpu_result_reader.sv
// rtl/fpu_result_reader.sv - holds an FPU result and pages it onto LEDs and seven-segment digits
module fpu_result_reader #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_CYCLES    = 25000000
) (
    input  logic        clk,
    input  logic        key3,
    input  logic [31:0] i_result,
    input  logic        i_zero_div,
    input  logic        i_result_valid,
    output logic        o_result_ready,
    input  logic        key0,
    output logic [17:0] o_LED_red,
    output logic [7:0]  o_LED_yellow,
    output logic        o_LED_zero,
    output logic [6:0]  o_HEX0,
    output logic [6:0]  o_HEX1,
    output logic [6:0]  o_HEX2,
    output logic [6:0]  o_HEX3
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BL_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [6:0]    BLANK   = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SHOW_HI, SHOW_LO} state_t;

    state_t         state;
    logic [31:0]    result_reg;
    logic           zero_reg;
    logic           rdy;
    logic           sync1, sync2, stable, stable_d;
    logic           live1, live2, armed;
    logic [DW-1:0]  db_cnt;
    logic [BW-1:0]  blink_cnt;
    logic           blink_on;
    logic           accept, press;
    logic [15:0]    page;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign o_result_ready = rdy & key3;
    assign accept         = i_result_valid & o_result_ready;
    assign press          = armed & stable_d & ~stable;
    assign page           = (state == SHOW_HI) ? result_reg[31:16] : result_reg[15:0];

    // A press only arms once the synchronized key has been seen released after reset,
    // so a button held through reset cannot fire on its own.
    always_ff @(posedge clk) begin
        if (!key3) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            stable   <= 1'b1;
            stable_d <= 1'b1;
            db_cnt   <= '0;
            live1    <= 1'b0;
            live2    <= 1'b0;
            armed    <= 1'b0;
        end else begin
            sync1    <= key0;
            sync2    <= sync1;
            stable_d <= stable;
            live1    <= 1'b1;
            live2    <= live1;
            armed    <= armed | (live2 & sync2);
            if (sync2 == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                stable <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!key3) begin
            blink_cnt <= '0;
            blink_on  <= 1'b0;
        end else if (accept) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BL_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // Outputs are registered from the current state, so they trail the state by one edge.
    always_ff @(posedge clk) begin
        if (!key3) begin
            state        <= IDLE;
            result_reg   <= '0;
            zero_reg     <= 1'b0;
            rdy          <= 1'b0;
            o_LED_red    <= '0;
            o_LED_yellow <= '0;
            o_LED_zero   <= 1'b0;
            o_HEX0       <= BLANK;
            o_HEX1       <= BLANK;
            o_HEX2       <= BLANK;
            o_HEX3       <= BLANK;
        end else begin
            rdy <= 1'b1;
            if (accept) begin
                state      <= SHOW_HI;
                result_reg <= i_result;
                zero_reg   <= i_zero_div;
            end else if (press) begin
                case (state)
                    SHOW_HI: state <= SHOW_LO;
                    SHOW_LO: state <= SHOW_HI;
                    default: state <= state;
                endcase
            end

            if (state == IDLE) begin
                o_LED_red    <= '0;
                o_LED_yellow <= '0;
                o_LED_zero   <= 1'b0;
                o_HEX0       <= BLANK;
                o_HEX1       <= BLANK;
                o_HEX2       <= BLANK;
                o_HEX3       <= BLANK;
            end else begin
                o_LED_red    <= {state == SHOW_HI, 1'b1, page};
                o_LED_yellow <= result_reg[30:23];
                o_LED_zero   <= zero_reg & blink_on;
                o_HEX0       <= hex7(page[3:0]);
                o_HEX1       <= hex7(page[7:4]);
                o_HEX2       <= hex7(page[11:8]);
                o_HEX3       <= hex7(page[15:12]);
            end
        end
    end

endmodule

// File: tb/tb_fpu_result_reader.sv
// tb/tb_fpu_result_reader.sv - directed bench for fpu_result_reader
module tb_fpu_result_reader;

    logic        clk = 1'b0;
    logic        key3;
    logic [31:0] i_result;
    logic        i_zero_div;
    logic        i_result_valid;
    logic        o_result_ready;
    logic        key0;
    logic [17:0] o_LED_red;
    logic [7:0]  o_LED_yellow;
    logic        o_LED_zero;
    logic [6:0]  o_HEX0, o_HEX1, o_HEX2, o_HEX3;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] BLANK = 7'b1111111;

    fpu_result_reader #(.DEBOUNCE_CYCLES(4), .BLINK_CYCLES(8)) dut (
        .clk(clk), .key3(key3), .i_result(i_result), .i_zero_div(i_zero_div),
        .i_result_valid(i_result_valid), .o_result_ready(o_result_ready), .key0(key0),
        .o_LED_red(o_LED_red), .o_LED_yellow(o_LED_yellow), .o_LED_zero(o_LED_zero),
        .o_HEX0(o_HEX0), .o_HEX1(o_HEX1), .o_HEX2(o_HEX2), .o_HEX3(o_HEX3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic accept(input logic [31:0] data, input logic zd);
        i_result       = data;
        i_zero_div     = zd;
        i_result_valid = 1'b1;
        tick();
        i_result_valid = 1'b0;
    endtask

    task automatic press();
        key0 = 1'b0;
        repeat (10) tick();
        key0 = 1'b1;
        repeat (10) tick();
    endtask

    task automatic check_hex(input string tag, input logic [27:0] exp);
        check({tag, "_hex3"}, {25'd0, o_HEX3}, {25'd0, exp[27:21]});
        check({tag, "_hex2"}, {25'd0, o_HEX2}, {25'd0, exp[20:14]});
        check({tag, "_hex1"}, {25'd0, o_HEX1}, {25'd0, exp[13:7]});
        check({tag, "_hex0"}, {25'd0, o_HEX0}, {25'd0, exp[6:0]});
    endtask

    task automatic check_blank(input string tag);
        check({tag, "_red"}, {14'd0, o_LED_red}, 32'h0);
        check({tag, "_yel"}, {24'd0, o_LED_yellow}, 32'h0);
        check({tag, "_zero"}, {31'd0, o_LED_zero}, 32'h0);
        check_hex(tag, {BLANK, BLANK, BLANK, BLANK});
    endtask

    initial begin
        key3 = 1'b0; key0 = 1'b1; i_result = '0; i_zero_div = 1'b0; i_result_valid = 1'b0;
        repeat (3) tick();
        check_blank("reset");
        check("reset_rdy", {31'd0, o_result_ready}, 32'd0);
        key3 = 1'b1;
        check("rel_rdy_pre", {31'd0, o_result_ready}, 32'd0);
        tick();
        check("rel_rdy", {31'd0, o_result_ready}, 32'd1);

        repeat (4) tick();
        press();
        check_blank("idle_press");

        accept(32'h40490FDB, 1'b0);
        tick();
        check("hi_red", {14'd0, o_LED_red}, 32'h34049);
        check("hi_yel", {24'd0, o_LED_yellow}, 32'h80);
        check("hi_zero", {31'd0, o_LED_zero}, 32'd0);
        check_hex("hi", {7'b0011001, 7'b1000000, 7'b0011001, 7'b0010000});

        press();
        check("lo_red", {14'd0, o_LED_red}, 32'h10FDB);
        check_hex("lo", {7'b1000000, 7'b0001110, 7'b0100001, 7'b0000011});
        press();
        check("hi2_red", {14'd0, o_LED_red}, 32'h34049);

        for (int i = 0; i < 5; i++) begin
            key0 = 1'b0; repeat (2) tick();
            key0 = 1'b1; repeat (2) tick();
        end
        repeat (10) tick();
        check("bounce_red", {14'd0, o_LED_red}, 32'h34049);

        accept(32'h00000000, 1'b1);
        for (int i = 0; i <= 16; i++) begin
            tick();
            check($sformatf("blink%0d", i), {31'd0, o_LED_zero}, {31'd0, (i < 8 || i == 16)});
        end
        check("dz_red", {14'd0, o_LED_red}, 32'h30000);

        accept(32'h12345678, 1'b0);
        tick();
        check("nz_red", {14'd0, o_LED_red}, 32'h31234);
        check("nz_yel", {24'd0, o_LED_yellow}, 32'h24);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("nz_zero%0d", i), {31'd0, o_LED_zero}, 32'd0);
        end

        press();
        check("col_pre", {14'd0, o_LED_red}, 32'h15678);
        key0 = 1'b0;
        repeat (6) tick();
        i_result = 32'h3F800000; i_zero_div = 1'b0; i_result_valid = 1'b1;
        tick();
        i_result_valid = 1'b0;
        tick();
        check("col_red", {14'd0, o_LED_red}, 32'h33F80);
        key0 = 1'b1;
        repeat (10) tick();
        check("col_after", {14'd0, o_LED_red}, 32'h33F80);

        key0 = 1'b0;
        repeat (3) tick();
        key3 = 1'b0;
        tick();
        check_blank("midrst");
        check("midrst_rdy", {31'd0, o_result_ready}, 32'd0);
        key3 = 1'b1;
        repeat (15) tick();
        accept(32'h40490FDB, 1'b0);
        repeat (15) tick();
        check("held_red", {14'd0, o_LED_red}, 32'h34049);
        key0 = 1'b1;
        repeat (12) tick();
        press();
        check("rearm_red", {14'd0, o_LED_red}, 32'h10FDB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
